// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer, flush and bubble clearing.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_skid #(
  parameter int DATA_W          = 128,
  parameter int CLEAR_ON_BUBBLE = 1,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Encoding equals the entry count; bit 1 doubles as skid_valid.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic              CLR  = (CLEAR_ON_BUBBLE != 0);
  localparam logic [DATA_W-1:0] ZERO = '0;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              skid_valid, up_fire, dn_fire;

  assign skid_valid = state_q[1];
  assign up_ready   = ~skid_valid;
  assign dn_valid   = (state_q != S_EMPTY);
  assign dn_data    = main_q;
  assign occupancy  = state_q;
  assign up_fire    = up_valid & up_ready;
  assign dn_fire    = dn_valid & dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: if (up_fire) begin
        state_d = S_ONE;
        main_d  = up_data;
      end
      S_ONE: begin
        if (up_fire && dn_fire) begin
          main_d = up_data;
        end else if (up_fire) begin
          state_d = S_FULL;
          skid_d  = up_data;
        end else if (dn_fire) begin
          state_d = S_EMPTY;
          if (CLR) main_d = ZERO;
        end
      end
      S_FULL: if (dn_fire) begin
        state_d = S_ONE;
        main_d  = skid_q;
        if (CLR) skid_d = ZERO;
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush overrides every transition above; a same-cycle up_fire is simply lost.
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = CLR ? ZERO : main_q;
      skid_d  = CLR ? ZERO : skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  cnt_t stall_q, bubble_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (dn_valid && !dn_ready && stall_q != '1) stall_q <= stall_q + cnt_t'(1);
      if (!dn_valid && bubble_q != '1)            bubble_q <= bubble_q + cnt_t'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic against a queue model,
// on two instances (CLEAR_ON_BUBBLE=1 with CNT_W=32, CLEAR_ON_BUBBLE=0 with CNT_W=4).
module tb_pipe_stage_skid;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, flush, up_valid, dn_ready;
  logic [DW-1:0] up_data;
  logic          up_ready, dn_valid, up_ready0, dn_valid0;
  logic [DW-1:0] dn_data, dn_data0;
  logic [1:0]    occupancy, occupancy0;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt;
  logic [3:0]    stall_cnt0, bubble_cnt0;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_BUBBLE(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_BUBBLE(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready0),
    .dn_valid(dn_valid0), .dn_data(dn_data0), .dn_ready(dn_ready),
    .occupancy(occupancy0)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
`endif
  );

  // Reference model: a FIFO of at most two entries, plus the last head value seen (what a
  // non-clearing stage keeps showing once empty) and plain cycle counts for the perf counters.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] held0 = '0;
  int            m_stall = 0, m_bubble = 0;
  bit            m_upf, m_dnf;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      held0    = '0;
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (mq.size() > 0 && !dn_ready) m_stall++;
      if (mq.size() == 0) m_bubble++;
      m_upf = up_valid && mq.size() < 2;
      m_dnf = mq.size() > 0 && dn_ready;
      if (flush) mq.delete();
      else begin
        if (m_dnf) void'(mq.pop_front());
        if (m_upf) mq.push_back(up_data);
      end
      if (mq.size() > 0) held0 = mq[0];
    end
  end

  task automatic idle(input int n);
    up_valid = 1'b0; dn_ready = 1'b1; flush = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic load_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
    dn_ready = 1'b0; up_valid = 1'b1; up_data = a;
    @(negedge clk);
    up_data = b;
    @(negedge clk);
    up_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({dn_valid, up_ready, occupancy, dn_data, dn_data0} !== {1'b0, 1'b1, 2'd0, 32'd0, 32'd0}) begin
      nerr++;
      $display("FAIL reset: v=%b r=%b occ=%0d d=%0h d0=%0h, want v=0 r=1 occ=0 d=0 d0=0",
               dn_valid, up_ready, occupancy, dn_data, dn_data0);
    end
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if ({up_ready, up_ready0, dn_valid} !== 3'b110) begin
      nerr++;
      $display("FAIL reset_release: r=%b r0=%b v=%b, want r=1 r0=1 v=0", up_ready, up_ready0, dn_valid);
    end
  endtask

  task automatic test_stream();
    dn_ready = 1'b1; flush = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1; up_data = DW'(i);
      @(negedge clk);
      nvec++;
      if ({dn_valid, up_ready, occupancy, dn_data} !== {1'b1, 1'b1, 2'd1, DW'(i)}) begin
        nerr++;
        $display("FAIL stream[%0d]: v=%b r=%b occ=%0d d=%0h, want v=1 r=1 occ=1 d=%0h",
                 i, dn_valid, up_ready, occupancy, dn_data, i);
      end
    end
    up_valid = 1'b0;
  endtask

  task automatic test_skid();
    idle(1);
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'hA;
    @(negedge clk);
    up_data = 32'hB;
    @(negedge clk);
    up_valid = 1'b0;
    nvec++;
    if ({dn_valid, up_ready, occupancy, dn_data} !== {1'b1, 1'b0, 2'd2, 32'hA}) begin
      nerr++;
      $display("FAIL skid_full: v=%b r=%b occ=%0d d=%0h, want v=1 r=0 occ=2 d=a",
               dn_valid, up_ready, occupancy, dn_data);
    end
    @(negedge clk);
    nvec++;
    if ({dn_valid, up_ready, dn_data} !== {1'b1, 1'b0, 32'hA}) begin
      nerr++;
      $display("FAIL skid_hold: v=%b r=%b d=%0h, want v=1 r=0 d=a", dn_valid, up_ready, dn_data);
    end
    dn_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if ({dn_valid, up_ready, occupancy, dn_data} !== {1'b1, 1'b1, 2'd1, 32'hB}) begin
      nerr++;
      $display("FAIL skid_drain: v=%b r=%b occ=%0d d=%0h, want v=1 r=1 occ=1 d=b",
               dn_valid, up_ready, occupancy, dn_data);
    end
    @(negedge clk);
    nvec++;
    if ({dn_valid, occupancy, dn_data} !== {1'b0, 2'd0, 32'h0}) begin
      nerr++;
      $display("FAIL skid_empty: v=%b occ=%0d d=%0h, want v=0 occ=0 d=0", dn_valid, occupancy, dn_data);
    end
  endtask

  task automatic test_flush_full();
    load_two(32'hA1, 32'hB2);
    flush = 1'b1; up_valid = 1'b1; up_data = 32'hC3;
    @(negedge clk);
    flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
    nvec++;
    if ({dn_valid, up_ready, occupancy, dn_data, dn_data0} !== {1'b0, 1'b1, 2'd0, 32'h0, 32'hA1}) begin
      nerr++;
      $display("FAIL flush_full: v=%b r=%b occ=%0d d=%0h d0=%0h, want v=0 r=1 occ=0 d=0 d0=a1",
               dn_valid, up_ready, occupancy, dn_data, dn_data0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (dn_valid !== 1'b0 || dn_data === 32'hC3) begin
        nerr++;
        $display("FAIL flush_drop[%0d]: v=%b d=%0h, want v=0 and never c3", i, dn_valid, dn_data);
      end
    end
  endtask

  task automatic test_bubble();
    dn_ready = 1'b1; up_valid = 1'b1; up_data = 32'h5EED;
    @(negedge clk);
    up_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if ({dn_valid, dn_data, dn_valid0, dn_data0} !== {1'b0, 32'h0, 1'b0, 32'h5EED}) begin
        nerr++;
        $display("FAIL bubble[%0d]: v=%b d=%0h v0=%b d0=%0h, want v=0 d=0 v0=0 d0=5eed",
                 i, dn_valid, dn_data, dn_valid0, dn_data0);
      end
    end
  endtask

  task automatic test_reset_midop();
    load_two(32'h11, 32'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nvec++;
    if ({dn_valid, up_ready, occupancy, dn_data, dn_data0, occupancy0} !==
        {1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 2'd0}) begin
      nerr++;
      $display("FAIL reset_midop: v=%b r=%b occ=%0d d=%0h d0=%0h occ0=%0d, want v=0 r=1 occ=0 d=0 d0=0 occ0=0",
               dn_valid, up_ready, occupancy, dn_data, dn_data0, occupancy0);
    end
    up_valid = 1'b1; up_data = 32'hD; dn_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    nvec++;
    if ({dn_valid, occupancy, dn_data} !== {1'b1, 2'd1, 32'hD}) begin
      nerr++;
      $display("FAIL reset_next: v=%b occ=%0d d=%0h, want v=1 occ=1 d=d", dn_valid, occupancy, dn_data);
    end
    @(negedge clk);
    nvec++;
    if ({dn_valid, occupancy} !== {1'b0, 2'd0}) begin
      nerr++;
      $display("FAIL reset_alone: v=%b occ=%0d, want v=0 occ=0", dn_valid, occupancy);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e_data, e_data0;
    for (int c = 0; c < 500; c++) begin
      up_valid = ($urandom_range(3) != 0);
      dn_ready = ($urandom_range(2) != 0);
      up_data  = $urandom;
      flush    = ($urandom_range(15) == 0);
      reset    = ($urandom_range(63) == 0);
      @(negedge clk);
      e_data  = (mq.size() > 0) ? mq[0] : '0;
      e_data0 = (mq.size() > 0) ? mq[0] : held0;
      nvec++;
      if ({dn_valid, up_ready, occupancy} !== {mq.size() > 0, mq.size() < 2, 2'(mq.size())} ||
          {dn_valid0, up_ready0, occupancy0} !== {dn_valid, up_ready, occupancy}) begin
        nerr++;
        $display("FAIL rand_ctl[%0d]: v=%b r=%b occ=%0d v0=%b r0=%b occ0=%0d, want occ=%0d",
                 c, dn_valid, up_ready, occupancy, dn_valid0, up_ready0, occupancy0, mq.size());
      end
      nvec++;
      if (dn_data !== e_data || dn_data0 !== e_data0) begin
        nerr++;
        $display("FAIL rand_data[%0d]: d=%0h d0=%0h, want d=%0h d0=%0h", c, dn_data, dn_data0, e_data, e_data0);
      end
`ifdef PIPE_STAGE_PERF_EN
      nvec++;
      if (stall_cnt !== 32'(m_stall) || bubble_cnt !== 32'(m_bubble) ||
          stall_cnt0 !== 4'((m_stall > 15) ? 15 : m_stall) || bubble_cnt0 !== 4'((m_bubble > 15) ? 15 : m_bubble)) begin
        nerr++;
        $display("FAIL rand_perf[%0d]: st=%0d bb=%0d st0=%0d bb0=%0d, want st=%0d bb=%0d (4b saturating)",
                 c, stall_cnt, bubble_cnt, stall_cnt0, bubble_cnt0, m_stall, m_bubble);
      end
`endif
    end
    reset = 1'b0; flush = 1'b0;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    reset = 1'b1; up_valid = 1'b0; dn_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    up_valid = 1'b1; up_data = 32'h77;
    @(negedge clk);
    up_valid = 1'b0;
    repeat (5) @(negedge clk);
    nvec++;
    if ({stall_cnt, bubble_cnt, stall_cnt0, bubble_cnt0} !== {32'd5, 32'd2, 4'd5, 4'd2}) begin
      nerr++;
      $display("FAIL perf_count: st=%0d bb=%0d st0=%0d bb0=%0d, want 5 2 5 2",
               stall_cnt, bubble_cnt, stall_cnt0, bubble_cnt0);
    end
    repeat (15) @(negedge clk);
    nvec++;
    if ({stall_cnt, stall_cnt0} !== {32'd20, 4'd15}) begin
      nerr++;
      $display("FAIL perf_sat: st=%0d st0=%0d, want st=20 st0=15", stall_cnt, stall_cnt0);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    nvec++;
    if ({stall_cnt, bubble_cnt} !== {32'd21, 32'd1 + 32'd2}) begin
      nerr++;
      $display("FAIL perf_flush: st=%0d bb=%0d, want st=21 bb=3", stall_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush_full();
    test_bubble();
    test_reset_midop();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
